ddr_strobe_seq: RTL and testbench

- Multi-channel, half-cycle-resolution bus strobe sequencer for the RV4028 external bus (mreq_n, wr_n, rd_n, iorq_n and similar).
- Turns one programmed bus cycle into active-low DDR strobe waveforms.
- Drives them through per-channel iCE40-style DDR output cells, so edges land on both clock phases.
- Replaces the hand-built two-channel DDR register pairs; adds configurable channel count, cycle length, wait-state stretching and timeout.

---
 rtl/ddr_strobe_pkg.sv | 25 ++
 rtl/ddr_out_cell.sv | 38 +++
 rtl/ddr_strobe_seq.sv | 208 ++++++++++++++++++++
 tb/tb_ddr_strobe_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_strobe_pkg.sv
// Shared types and helpers for the RV4028 DDR strobe sequencer.
// Holds the sequencer state encoding, the idle (inactive) strobe level and
// the width helpers used to size the cycle counter and half-slot numbers.
package ddr_strobe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } seqState_e;

    // Strobes are active low, so the parked level is high.
    localparam logic STROBE_IDLE = 1'b1;

    // Bits needed to hold a clock count 0..maxClks.
    function automatic int cycWidth(input int maxClks);
        return $clog2(maxClks + 1);
    endfunction

    // Bits needed to hold a half-slot number 0..2*maxClks.
    function automatic int slotWidth(input int maxClks);
        return $clog2(2 * maxClks + 1);
    endfunction

endpackage

// File: rtl/ddr_out_cell.sv
// One DDR output pin modelled on the iCE40 SB_IO DDR output register pair.
// dPos_i is captured on the rising edge and driven while clk is high,
// dNeg_i is captured on the falling edge and driven while clk is low.
// Both registers set asynchronously to the idle strobe level on rst.
module ddr_out_cell
    import ddr_strobe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic dPos_i,
    input  logic dNeg_i,
    output logic pin_o
);

    logic posR_q;
    logic negR_q;

    // Rising-edge half of the pair: value shown during the clk-high phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            posR_q <= STROBE_IDLE;
        end else begin
            posR_q <= dPos_i;
        end
    end

    // Falling-edge half of the pair: value shown during the clk-low phase.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            negR_q <= STROBE_IDLE;
        end else begin
            negR_q <= dNeg_i;
        end
    end

    assign pin_o = clk ? posR_q : negR_q;

endmodule

// File: rtl/ddr_strobe_seq.sv
// Multi-channel half-cycle bus strobe sequencer for the RV4028 external bus.
// One accepted bus cycle is expanded into active-low strobe waveforms with
// half-clock resolution and driven out through per-channel DDR cells.
//
// Build option: define DDR_STROBE_WAIT_EN to include wait-state stretching
// (wait_n sampled at clock wait_cyc) with a WAIT_TIMEOUT abort and err pulse.
// Without it every cycle lasts exactly len clocks and err stays low.
//
// Pipeline: the value for even slot 2c is registered in posVal_q at E(c) and
// the value for odd slot 2c+1 in negVal_q at E(c+1); the cells add one more
// register stage, so slot 0 appears in the high phase after E1.
module ddr_strobe_seq
    import ddr_strobe_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int MAX_CLKS     = 8,
    parameter int WAIT_TIMEOUT = 255,
    localparam int CW = cycWidth(MAX_CLKS),
    localparam int SW = slotWidth(MAX_CLKS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     ready,
    input  logic [CW-1:0]            len,
    input  logic [CHANNELS*SW-1:0]   assert_slot,
    input  logic [CHANNELS*SW-1:0]   deassert_slot,
    input  logic [CHANNELS-1:0]      chan_en,
    input  logic [CW-1:0]            wait_cyc,
    input  logic                     wait_n,
    output logic                     done,
    output logic                     err,
    output logic [CHANNELS-1:0]      strobe_n
);

    localparam logic [CHANNELS-1:0] ALL_IDLE = {CHANNELS{STROBE_IDLE}};

    seqState_e                 state_q, state_d;
    logic [CW-1:0]             cyc_q, cyc_d;
    logic [CW-1:0]             lastCyc_q, lastCyc_d;
    logic [CHANNELS-1:0]       chanEn_q, chanEn_d;
    logic [CHANNELS*SW-1:0]    assertSlot_q, assertSlot_d;
    logic [CHANNELS*SW-1:0]    deassertSlot_q, deassertSlot_d;
    logic [CHANNELS-1:0]       posVal_q, posVal_d;
    logic [CHANNELS-1:0]       negVal_q, negVal_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      abortNow;
    logic [CHANNELS-1:0]       cellPos;
    logic [SW-1:0]             slotEven;
    logic [SW-1:0]             slotOdd;
    logic [SW-1:0]             slotNext;

`ifdef DDR_STROBE_WAIT_EN
    localparam int WW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
    logic [CW-1:0]             waitCyc_q, waitCyc_d;
    logic [WW-1:0]             waitCnt_q, waitCnt_d;
`else
    localparam int unusedTimeout = WAIT_TIMEOUT;
    logic unusedWaitInputs;
    assign unusedWaitInputs = ^{wait_n, wait_cyc};
`endif

    // Pin levels for every channel in half-slot s under a given configuration.
    function automatic logic [CHANNELS-1:0] slotLevels(
        input logic [SW-1:0]          s,
        input logic [CHANNELS-1:0]    en,
        input logic [CHANNELS*SW-1:0] asv,
        input logic [CHANNELS*SW-1:0] dsv
    );
        logic [CHANNELS-1:0] lv;
        lv = ALL_IDLE;
        for (int i = 0; i < CHANNELS; i++) begin
            if (en[i] && (asv[i*SW +: SW] <= s) && (s < dsv[i*SW +: SW])) begin
                lv[i] = ~STROBE_IDLE;
            end
        end
        return lv;
    endfunction

    assign slotEven = SW'({cyc_q, 1'b0});
    assign slotOdd  = SW'({cyc_q, 1'b1});
    assign slotNext = slotEven + SW'(2);

    // Sequencer next-state: accept, advance one bus clock per edge, stretch on wait.
    always_comb begin
        state_d        = state_q;
        cyc_d          = cyc_q;
        lastCyc_d      = lastCyc_q;
        chanEn_d       = chanEn_q;
        assertSlot_d   = assertSlot_q;
        deassertSlot_d = deassertSlot_q;
        posVal_d       = posVal_q;
        negVal_d       = negVal_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        abortNow       = 1'b0;
`ifdef DDR_STROBE_WAIT_EN
        waitCyc_d      = waitCyc_q;
        waitCnt_d      = waitCnt_q;
`endif
        case (state_q)
            IDLE: begin
                posVal_d = ALL_IDLE;
                negVal_d = ALL_IDLE;
                if (start) begin
                    state_d        = RUN;
                    cyc_d          = '0;
                    lastCyc_d      = (len == '0) ? '0 : (len - CW'(1));
                    chanEn_d       = chan_en;
                    assertSlot_d   = assert_slot;
                    deassertSlot_d = deassert_slot;
                    posVal_d       = slotLevels('0, chan_en, assert_slot, deassert_slot);
`ifdef DDR_STROBE_WAIT_EN
                    waitCyc_d      = wait_cyc;
`endif
                end
            end
            RUN, WAIT: begin
                negVal_d = slotLevels(slotOdd, chanEn_q, assertSlot_q, deassertSlot_q);
`ifdef DDR_STROBE_WAIT_EN
                if ((state_q == WAIT) && !wait_n) begin
                    posVal_d = slotLevels(slotEven, chanEn_q, assertSlot_q, deassertSlot_q);
                    if (waitCnt_q == WW'(WAIT_TIMEOUT - 1)) begin
                        state_d  = IDLE;
                        err_d    = 1'b1;
                        posVal_d = ALL_IDLE;
                        negVal_d = ALL_IDLE;
                        abortNow = 1'b1;
                    end else begin
                        waitCnt_d = waitCnt_q + WW'(1);
                    end
                end else if ((cyc_q == waitCyc_q) && !wait_n) begin
                    state_d   = WAIT;
                    waitCnt_d = '0;
                    posVal_d  = slotLevels(slotEven, chanEn_q, assertSlot_q, deassertSlot_q);
                end else
`endif
                if (cyc_q == lastCyc_q) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    posVal_d = ALL_IDLE;
                end else begin
                    state_d  = RUN;
                    cyc_d    = cyc_q + CW'(1);
                    posVal_d = slotLevels(slotNext, chanEn_q, assertSlot_q, deassertSlot_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, latched configuration and the slot values feeding the cells.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cyc_q          <= '0;
            lastCyc_q      <= '0;
            chanEn_q       <= '0;
            assertSlot_q   <= '0;
            deassertSlot_q <= '0;
            posVal_q       <= ALL_IDLE;
            negVal_q       <= ALL_IDLE;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef DDR_STROBE_WAIT_EN
            waitCyc_q      <= '0;
            waitCnt_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cyc_q          <= cyc_d;
            lastCyc_q      <= lastCyc_d;
            chanEn_q       <= chanEn_d;
            assertSlot_q   <= assertSlot_d;
            deassertSlot_q <= deassertSlot_d;
            posVal_q       <= posVal_d;
            negVal_q       <= negVal_d;
            done_q         <= done_d;
            err_q          <= err_d;
`ifdef DDR_STROBE_WAIT_EN
            waitCyc_q      <= waitCyc_d;
            waitCnt_q      <= waitCnt_d;
`endif
        end
    end

    // A timeout parks the rising-edge registers at once so the pins go high
    // from the very next slot instead of replaying the stretched one.
    assign cellPos = abortNow ? ALL_IDLE : posVal_q;

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign err   = err_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : gCell
        ddr_out_cell uCell (
            .clk    (clk),
            .rst    (rst),
            .dPos_i (cellPos[g]),
            .dNeg_i (negVal_q[g]),
            .pin_o  (strobe_n[g])
        );
    end

endmodule

// File: tb/tb_ddr_strobe_seq.sv
// Scoreboard bench for ddr_strobe_seq (two channels, MAX_CLKS=8, WAIT_TIMEOUT=4).
// Stimulus pushes hand-computed strobe masks per bus cycle; a monitor records
// the pin level in every half-slot from accept to done/err and compares.
// Wait-stretch and timeout cycles are exercised when DDR_STROBE_WAIT_EN is set.
module tb_ddr_strobe_seq;

    localparam int CH  = 2;
    localparam int CW  = 4;
    localparam int SW  = 5;
    localparam int TMO = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic              ready;
    logic [CW-1:0]     len;
    logic [CH*SW-1:0]  assert_slot;
    logic [CH*SW-1:0]  deassert_slot;
    logic [CH-1:0]     chan_en;
    logic [CW-1:0]     wait_cyc;
    logic              wait_n;
    logic              done;
    logic              err;
    logic [CH-1:0]     strobe_n;

    typedef struct {
        int          clocks;
        bit          isErr;
        logic [31:0] mask0;
        logic [31:0] mask1;
    } exp_t;

    exp_t expQ[$];
    int   checksTotal  = 0;
    int   checksPassed = 0;

    ddr_strobe_seq #(
        .CHANNELS     (CH),
        .MAX_CLKS     (8),
        .WAIT_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .ready         (ready),
        .len           (len),
        .assert_slot   (assert_slot),
        .deassert_slot (deassert_slot),
        .chan_en       (chan_en),
        .wait_cyc      (wait_cyc),
        .wait_n        (wait_n),
        .done          (done),
        .err           (err),
        .strobe_n      (strobe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checksTotal++;
        if (act === expv) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic pushExp(input int clocks, input bit isErr, input logic [31:0] m0, input logic [31:0] m1);
        exp_t e;
        e.clocks = clocks;
        e.isErr  = isErr;
        e.mask0  = m0;
        e.mask1  = m1;
        expQ.push_back(e);
    endtask

    task automatic driveConfig(input int lenV, input logic [1:0] en,
                               input int as0, input int ds0, input int as1, input int ds1, input int wc);
        len           = CW'(lenV);
        chan_en       = en;
        assert_slot   = {SW'(as1), SW'(as0)};
        deassert_slot = {SW'(ds1), SW'(ds0)};
        wait_cyc      = CW'(wc);
    endtask

    task automatic scramble();
        len           = CW'($urandom);
        chan_en       = CH'($urandom);
        assert_slot   = (CH*SW)'($urandom);
        deassert_slot = (CH*SW)'($urandom);
        wait_cyc      = CW'($urandom);
    endtask

    task automatic waitForReady(input string tag);
        int k;
        k = 0;
        while (!ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, 32'(ready), 32'd1);
    endtask

    // One bus cycle from a negedge with ready=1; returns at the negedge where ready is back.
    task automatic applyStimulus(input string tag, input int lenV, input logic [1:0] en,
                                 input int as0, input int ds0, input int as1, input int ds1,
                                 input int wc, input bit holdWaitLow, input int releaseNeg);
        int n;
        waitForReady({tag, "_readyBefore"});
        driveConfig(lenV, en, as0, ds0, as1, ds1, wc);
        wait_n = holdWaitLow ? 1'b0 : 1'b1;
        start  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                scramble();
            end
            if (n == releaseNeg) wait_n = 1'b1;
        end while (!(n >= 2 && ready) && n < 60);
        wait_n = 1'b1;
        checkOutput({tag, "_readyBack"}, 32'(ready), 32'd1);
    endtask

    // Monitor: capture half-slot pin levels per accepted cycle and score them.
    initial begin : monitor
        bit          acc;
        bit          gotDone;
        bit          gotErr;
        bit          aborted;
        int          clocks;
        int          n;
        int          txId;
        logic [1:0]  trace [0:127];
        logic [1:0]  expSlot;
        exp_t        e;
        acc  = 1'b0;
        txId = 0;
        forever begin
            if (!acc) begin
                @(posedge clk);
                acc = ready && start && !rst;
            end
            if (acc) begin
                acc     = 1'b0;
                clocks  = 0;
                n       = 0;
                gotDone = 1'b0;
                gotErr  = 1'b0;
                aborted = 1'b0;
                while (!(gotDone || gotErr) && !aborted && clocks < 40) begin
                    @(posedge clk);
                    #1;
                    clocks++;
                    if (rst) begin
                        aborted = 1'b1;
                    end else begin
                        trace[n] = strobe_n;
                        n++;
                        gotDone = done;
                        gotErr  = err;
                        @(negedge clk);
                        #1;
                        if (rst) begin
                            aborted = 1'b1;
                        end else begin
                            trace[n] = strobe_n;
                            n++;
                        end
                    end
                end
                if (!aborted) begin
                    @(posedge clk);
                    acc = ready && start && !rst;
                    #1;
                    trace[n] = strobe_n;
                    n++;
                    if (expQ.size() == 0) begin
                        checkOutput($sformatf("tx%0d_unexpected", txId), 32'd1, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput($sformatf("tx%0d_clocks", txId), 32'(clocks), 32'(e.clocks));
                        checkOutput($sformatf("tx%0d_err", txId), 32'(gotErr), 32'(e.isErr));
                        checkOutput($sformatf("tx%0d_done", txId), 32'(gotDone), 32'(!e.isErr));
                        if (clocks == e.clocks) begin
                            for (int s = 0; s <= 2 * e.clocks; s++) begin
                                if (s < 2 * e.clocks) expSlot = {~e.mask1[s], ~e.mask0[s]};
                                else                  expSlot = 2'b11;
                                checkOutput($sformatf("tx%0d_slot%0d", txId, s), 32'(trace[s]), 32'(expSlot));
                            end
                        end
                    end
                    txId++;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst   = 1'b1;
        start = 1'b0;
        wait_n = 1'b1;
        driveConfig(0, 2'b00, 0, 0, 0, 0, 0);
        #3;
        checkOutput("resetStrobe", 32'(strobe_n), 32'h3);
        checkOutput("resetReady", 32'(ready), 32'd1);
        checkOutput("resetDoneErr", 32'({err, done}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic cycle len=3");
        pushExp(3, 1'b0, 32'h1E, 32'h3C);
        applyStimulus("basic", 3, 2'b11, 1, 5, 2, 6, 15, 1'b0, 0);

        $display("[TB] reset during slot 3");
        waitForReady("rstReadyBefore");
        driveConfig(4, 2'b11, 0, 8, 3, 4, 15);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        checkOutput("preResetSlot3", 32'(strobe_n), 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("asyncResetStrobe", 32'(strobe_n), 32'h3);
        checkOutput("asyncResetReady", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("resetNoDoneErr", 32'({err, done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("afterResetNoDone", 32'({err, done}), 32'd0);
        @(negedge clk);

        $display("[TB] cycle after reset");
        pushExp(2, 1'b0, 32'h03, 32'h08);
        applyStimulus("postReset", 2, 2'b11, 0, 2, 3, 4, 15, 1'b0, 0);

`ifdef DDR_STROBE_WAIT_EN
        $display("[TB] wait stretch");
        pushExp(7, 1'b0, 32'h3FE, 32'h3EA8);
        applyStimulus("waitStretch", 4, 2'b11, 1, 4, 3, 8, 1, 1'b1, 5);

        $display("[TB] wait timeout");
        pushExp(5, 1'b1, 32'hFF, 32'hAA);
        applyStimulus("timeout", 3, 2'b11, 0, 6, 1, 2, 0, 1'b1, 99);
`else
        $display("[TB] wait_n ignored without wait support");
        pushExp(4, 1'b0, 32'h0E, 32'hF8);
        applyStimulus("waitIgnored", 4, 2'b11, 1, 4, 3, 8, 1, 1'b1, 99);
`endif

        $display("[TB] degenerate len=0, disabled and empty channels");
        pushExp(1, 1'b0, 32'h0, 32'h0);
        applyStimulus("degenerate", 0, 2'b01, 3, 3, 0, 2, 15, 1'b0, 0);

        $display("[TB] full length cycle");
        pushExp(8, 1'b0, 32'hFFFF, 32'h8000);
        applyStimulus("maxLen", 8, 2'b11, 0, 16, 15, 16, 15, 1'b0, 0);

        $display("[TB] deassert before assert");
        pushExp(2, 1'b0, 32'h0, 32'h06);
        applyStimulus("reversed", 2, 2'b11, 3, 1, 1, 3, 15, 1'b0, 0);

        $display("[TB] start while busy and during done");
        pushExp(3, 1'b0, 32'h3F, 32'h06);
        pushExp(2, 1'b0, 32'h0C, 32'h01);
        waitForReady("busyReadyBefore");
        driveConfig(3, 2'b11, 0, 6, 1, 3, 15);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        @(negedge clk);
        driveConfig(1, 2'b11, 0, 2, 0, 2, 15);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("busyDonePulse", 32'(done), 32'd1);
        checkOutput("busyReadyWithDone", 32'(ready), 32'd1);
        driveConfig(2, 2'b11, 2, 4, 0, 1, 15);
        @(negedge clk);
        start = 1'b0;
        scramble();
        checkOutput("acceptedAfterDone", 32'(ready), 32'd0);
        waitForReady("busyReadyAfter");

        for (int k = 0; k < 50 && expQ.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
